fetch_resp_queue: RTL and testbench
===================================

Name: fetch_resp_queue

Overview:
- Sits directly downstream of the instruction-cache interface and upstream of decode.
- Pairs each returned instruction word (or page fault) with the PC of the request that produced it, and buffers pairs in a FIFO towards decode.
- Grants request credits to fetch so the queue can never overflow.
- Discards responses belonging to requests killed by a pipeline flush.

Parameters:
- DEPTH, 4, instruction queue entries (power of two, >=2).
- MAX_INFLIGHT, 2, maximum issued-but-unanswered requests (power of two, >=1).
- PC_WIDTH, 40, PC width; equals drac_pkg PHY_VIRT_MAX_ADDR_SIZE.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset. Asynchronous, active-low.
- req_fire_i  in  1  request accepted by the cache interface this cycle (valid & ready).
- req_pc_i  in  PC_WIDTH  PC of the accepted request.
- resp_valid_i  in  1  response valid from the cache interface.
- resp_data_i  in  32  instruction word.
- resp_pf_i  in  1  instruction page fault flag.
- flush_i  in  1  kill all buffered and in-flight fetches.
- req_allow_o  out  1  fetch may issue a request this cycle.
- deq_valid_o  out  1  head entry valid.
- deq_ready_i  in  1  decode accepts the head entry.
- deq_pc_o  out  PC_WIDTH  head PC.
- deq_instr_o  out  32  head instruction; forced 0 when deq_pf_o=1.
- deq_pf_o  out  1  head page fault.
- count_o  out  $clog2(DEPTH)+1  queue occupancy.
- drop_pulse_o  out  1  a killed response was discarded this cycle (PMU).

Behaviour:
Reset:
- Pointers, occupancy and in-flight counters are 0; kill_cnt is 0; state is RUN.
- Output values at reset: req_allow_o=1, deq_valid_o=0, count_o=0, drop_pulse_o=0.
- deq_pc_o, deq_instr_o and deq_pf_o are all 0 at reset.

In-flight PC FIFO (MAX_INFLIGHT deep):
- Pushed on req_fire_i.
- Popped on resp_valid_i.
- Responses return strictly in order.

Credit:
- req_allow_o = (count + inflight < DEPTH) && (inflight < MAX_INFLIGHT) && !flush_i.
- req_allow_o is combinational from registered state plus flush_i.

Enqueue:
- In state RUN, resp_valid_i pops the in-flight PC and writes {pc, data, pf} at the tail.
- The entry is visible on deq_* the next cycle (1-cycle latency).

Dequeue:
- deq_valid_o && deq_ready_i advances the head.
- Enqueue and dequeue in the same cycle leave count unchanged. This is legal at full and at empty.
- Pointers wrap modulo DEPTH.

States:
- RUN: normal operation.
  - flush_i clears the queue (count=0, head=tail) and empties the in-flight PC FIFO.
  - kill_cnt is set to the in-flight count, plus 1 if req_fire_i is also high in the flush cycle (that request is killed too), minus 1 if resp_valid_i is also high in the flush cycle (that response is dropped).
  - If the resulting kill_cnt > 0, go to DRAIN; otherwise stay in RUN.
- DRAIN:
  - Each resp_valid_i decrements kill_cnt, pulses drop_pulse_o, and is not enqueued.
  - At kill_cnt reaching 0, return to RUN.
  - req_allow_o is 0 in DRAIN.
  - flush_i in DRAIN holds kill_cnt (minus any simultaneous response).
- deq_valid_o=0 during the flush cycle's successor until new data arrives.

Boundary conditions:
- A response with inflight=0 in RUN is an error. It is ignored, and a simulation assertion fires.
- A response arriving when the queue is full is unreachable by credit. It is covered by an assertion.
- req_fire_i while req_allow_o=0 is an assertion error.

Optional Feature:
- Macro: FETCH_RESP_QUEUE_BYPASS_EN.
- When defined:
  - In RUN, with count=0 and resp_valid_i=1, the response drives deq_* combinationally and deq_valid_o=1 in the same cycle.
  - If deq_ready_i=1, nothing is written; otherwise the entry is enqueued as usual.
- When undefined: there is always a 1-cycle queue latency and deq_* come only from registers.

Decomposition:
- In drac_pkg:
  - fetch_q_entry_t {pc, instr, pf};
  - fetch_q_state_t {RUN, DRAIN};
  - default constants FETCH_Q_DEPTH and FETCH_Q_MAX_INFLIGHT.
- Sub-module: fetch_q_fifo, a generic synchronous FIFO (parameterised width and depth, flush input).
  - Instantiated twice: once for the in-flight PCs and once for the entry queue.
- The top level holds the credit logic, kill_cnt and the FSM.

Test Plan:
1. Issue PCs 0x1000, 0x1004; respond 0x00000013, 0x00100093 with deq_ready_i=1 → decode sees (0x1000,0x13) then (0x1004,0x00100093), count_o returns to 0.
2. deq_ready_i=0, issue until req_allow_o drops → exactly 4 entries queued, req_allow_o=0 while count+inflight=4; one dequeue re-asserts it the next cycle.
3. Two requests in flight, flush_i pulsed → state DRAIN, the next two responses are dropped with drop_pulse_o high twice, count_o stays 0, RUN resumes and req_allow_o=1.
4. flush_i, req_fire_i and resp_valid_i in the same cycle with inflight=1 → kill_cnt=1, and the next response is dropped.
5. Response with resp_pf_i=1 and data 0xDEADBEEF at PC 0x2000 → deq_pf_o=1, deq_instr_o=0, deq_pc_o=0x2000.
6. Reset asserted mid-DRAIN with a full queue → all outputs reach their reset values immediately, with no stale entries after release.

Source files
------------

// File: rtl/fetch_resp_queue_pkg.sv
// Shared types and default constants for the fetch response queue.
// The optional same-cycle bypass is enabled by FETCH_RESP_QUEUE_BYPASS_EN.
package fetch_resp_queue_pkg;

  localparam int PHY_VIRT_MAX_ADDR_SIZE = 40;
  localparam int FETCH_Q_DEPTH          = 4;
  localparam int FETCH_Q_MAX_INFLIGHT   = 2;

  // Layout of one queue entry; the queue stores it packed as {pc, instr, pf}.
  typedef struct packed {
    logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] pc;
    logic [31:0]                       instr;
    logic                              pf;
  } fetch_q_entry_t;

  typedef enum logic [0:0] {
    FQ_RUN   = 1'b0,
    FQ_DRAIN = 1'b1
  } fetch_q_state_t;

  // A faulting fetch carries no usable instruction, so its word is zeroed.
  function automatic logic [31:0] fq_mask_instr(input logic [31:0] instr,
                                                input logic        pf);
    return pf ? 32'd0 : instr;
  endfunction

endpackage

// File: rtl/fetch_q_fifo.sv
// Generic synchronous FIFO with a synchronous flush that empties it.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_q_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic             do_pop_s;
  logic             do_push_s;

  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : (p + AW'(1));
  endfunction

  assign do_pop_s  = pop_i && (count_r != {CW{1'b0}});
  assign do_push_s = push_i && ((count_r != CW'(DEPTH)) || do_pop_s);
  assign dout_o    = mem_r[head_r];
  assign count_o   = count_r;

  // Entry storage: cleared on reset so nothing stale is ever presented
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s && !flush_i) begin
      mem_r[tail_r] <= din_i;
    end
  end

  // Head/tail pointers and occupancy; flush wins over push and pop
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (flush_i) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        tail_r <= inc_ptr(tail_r);
      end
      if (do_pop_s) begin
        head_r <= inc_ptr(head_r);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/fetch_resp_queue_chk.sv
// Protocol checker for the fetch response queue: illegal responses,
// overflow of the entry queue and requests issued without credit.
module fetch_resp_queue_chk (
  input logic clk_i,
  input logic rstn_i,
  input logic run_i,
  input logic resp_valid_i,
  input logic inflight_zero_i,
  input logic enq_i,
  input logic queue_full_i,
  input logic deq_pop_i,
  input logic req_fire_i,
  input logic credit_ok_i
);

  a_resp_without_request: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(run_i && resp_valid_i && inflight_zero_i))
    else $error("fetch_resp_queue: response with no request in flight");

  a_enqueue_when_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(enq_i && queue_full_i && !deq_pop_i))
    else $error("fetch_resp_queue: response arrived with the queue full");

  // The flush term is left out: a request already accepted by the cache in
  // the flush cycle is legal and simply gets killed.
  a_request_without_credit: assert property (@(posedge clk_i) disable iff (!rstn_i)
    req_fire_i |-> (run_i && credit_ok_i))
    else $error("fetch_resp_queue: request issued without credit");

endmodule

// File: rtl/fetch_resp_queue.sv
// Fetch response queue: pairs instruction-cache responses with their request
// PCs, buffers them towards decode, grants request credit and drops responses
// of flushed requests. Define FETCH_RESP_QUEUE_BYPASS_EN to let a response
// reach decode in its arrival cycle when the queue is empty.
module fetch_resp_queue
  import fetch_resp_queue_pkg::*;
#(
  parameter int DEPTH        = FETCH_Q_DEPTH,
  parameter int MAX_INFLIGHT = FETCH_Q_MAX_INFLIGHT,
  parameter int PC_WIDTH     = PHY_VIRT_MAX_ADDR_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       req_fire_i,
  input  logic [PC_WIDTH-1:0]        req_pc_i,
  input  logic                       resp_valid_i,
  input  logic [31:0]                resp_data_i,
  input  logic                       resp_pf_i,
  input  logic                       flush_i,
  output logic                       req_allow_o,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [PC_WIDTH-1:0]        deq_pc_o,
  output logic [31:0]                deq_instr_o,
  output logic                       deq_pf_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_pulse_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int KW = $clog2(MAX_INFLIGHT + 2);
  localparam int EW = PC_WIDTH + 33;

  localparam logic [0:0] ST_RUN   = FQ_RUN;
  localparam logic [0:0] ST_DRAIN = FQ_DRAIN;

  logic [0:0]          state_r;
  logic [0:0]          state_n;
  logic [KW-1:0]       kill_cnt_r;
  logic [KW-1:0]       kill_n;
  logic                drop_pulse_s;
  logic [IW-1:0]       inflight_s;
  logic [PC_WIDTH-1:0] head_pc_s;
  logic [CW-1:0]       count_s;
  logic [EW-1:0]       q_head_s;
  logic [EW-1:0]       entry_in_s;
  logic                run_s;
  logic                resp_ok_s;
  logic                credit_ok_s;
  logic                enq_s;
  logic                bypass_s;
  logic                q_push_s;
  logic                q_pop_s;

  assign run_s       = (state_r == ST_RUN);
  assign resp_ok_s   = resp_valid_i && (inflight_s != {IW{1'b0}});
  assign credit_ok_s = ((int'(count_s) + int'(inflight_s)) < DEPTH) &&
                       (int'(inflight_s) < MAX_INFLIGHT);
  assign req_allow_o = run_s && credit_ok_s && !flush_i;
  assign enq_s       = run_s && resp_ok_s && !flush_i;
  assign entry_in_s  = {head_pc_s, fq_mask_instr(resp_data_i, resp_pf_i), resp_pf_i};

`ifdef FETCH_RESP_QUEUE_BYPASS_EN
  assign bypass_s = enq_s && (count_s == {CW{1'b0}});
`else
  assign bypass_s = 1'b0;
`endif

  assign q_push_s     = enq_s && !(bypass_s && deq_ready_i);
  assign q_pop_s      = (count_s != {CW{1'b0}}) && deq_ready_i;
  assign count_o      = count_s;
  assign drop_pulse_o = drop_pulse_s;

  // PCs of issued-but-unanswered requests, in issue order
  fetch_q_fifo #(
    .WIDTH (PC_WIDTH),
    .DEPTH (MAX_INFLIGHT)
  ) u_inflight_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .push_i  (req_fire_i && run_s),
    .din_i   (req_pc_i),
    .pop_i   (resp_ok_s),
    .dout_o  (head_pc_s),
    .count_o (inflight_s)
  );

  // Completed {pc, instr, pf} entries waiting for decode
  fetch_q_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_entry_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .push_i  (q_push_s),
    .din_i   (entry_in_s),
    .pop_i   (q_pop_s),
    .dout_o  (q_head_s),
    .count_o (count_s)
  );

  // Decode-side view: queue head, or the arriving response when bypassing
  always_comb begin
    deq_valid_o = (count_s != {CW{1'b0}});
    deq_pc_o    = q_head_s[EW-1 -: PC_WIDTH];
    deq_instr_o = q_head_s[32:1];
    deq_pf_o    = q_head_s[0];
    if (bypass_s) begin
      deq_valid_o = 1'b1;
      deq_pc_o    = head_pc_s;
      deq_instr_o = fq_mask_instr(resp_data_i, resp_pf_i);
      deq_pf_o    = resp_pf_i;
    end else begin
      deq_valid_o = (count_s != {CW{1'b0}});
    end
  end

  // Flush/drain sequencing: how many killed responses remain to be discarded
  always_comb begin
    state_n      = state_r;
    kill_n       = kill_cnt_r;
    drop_pulse_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (flush_i) begin
          kill_n       = KW'(inflight_s) + KW'(req_fire_i) - KW'(resp_ok_s);
          drop_pulse_s = resp_ok_s;
          if (kill_n != {KW{1'b0}}) begin
            state_n = ST_DRAIN;
          end else begin
            state_n = ST_RUN;
          end
        end else begin
          kill_n  = {KW{1'b0}};
          state_n = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (resp_valid_i && (kill_cnt_r != {KW{1'b0}})) begin
          kill_n       = kill_cnt_r - KW'(1);
          drop_pulse_s = 1'b1;
          if (kill_n == {KW{1'b0}}) begin
            state_n = ST_RUN;
          end else begin
            state_n = ST_DRAIN;
          end
        end else begin
          state_n = ST_DRAIN;
        end
      end
      default: begin
        state_n = ST_RUN;
        kill_n  = {KW{1'b0}};
      end
    endcase
  end

  // State and kill counter registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r    <= ST_RUN;
      kill_cnt_r <= {KW{1'b0}};
    end else begin
      state_r    <= state_n;
      kill_cnt_r <= kill_n;
    end
  end

  fetch_resp_queue_chk u_chk (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .run_i           (run_s),
    .resp_valid_i    (resp_valid_i),
    .inflight_zero_i (inflight_s == {IW{1'b0}}),
    .enq_i           (enq_s),
    .queue_full_i    (count_s == CW'(DEPTH)),
    .deq_pop_i       (q_pop_s),
    .req_fire_i      (req_fire_i),
    .credit_ok_i     (credit_ok_s)
  );

endmodule

// File: tb/tb_fetch_resp_queue.sv
// Directed self-checking bench for fetch_resp_queue (default build, no bypass).
module tb_fetch_resp_queue;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        req_fire_i;
  logic [39:0] req_pc_i;
  logic        resp_valid_i;
  logic [31:0] resp_data_i;
  logic        resp_pf_i;
  logic        flush_i;
  logic        req_allow_o;
  logic        deq_valid_o;
  logic        deq_ready_i;
  logic [39:0] deq_pc_o;
  logic [31:0] deq_instr_o;
  logic        deq_pf_o;
  logic [2:0]  count_o;
  logic        drop_pulse_o;

  int vectors = 0;
  int miscompares = 0;

  fetch_resp_queue dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .req_fire_i   (req_fire_i),
    .req_pc_i     (req_pc_i),
    .resp_valid_i (resp_valid_i),
    .resp_data_i  (resp_data_i),
    .resp_pf_i    (resp_pf_i),
    .flush_i      (flush_i),
    .req_allow_o  (req_allow_o),
    .deq_valid_o  (deq_valid_o),
    .deq_ready_i  (deq_ready_i),
    .deq_pc_o     (deq_pc_o),
    .deq_instr_o  (deq_instr_o),
    .deq_pf_o     (deq_pf_o),
    .count_o      (count_o),
    .drop_pulse_o (drop_pulse_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_fire_i   = 1'b0;
    req_pc_i     = 40'h0;
    resp_valid_i = 1'b0;
    resp_data_i  = 32'h0;
    resp_pf_i    = 1'b0;
    flush_i      = 1'b0;
    deq_ready_i  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rstn_i = 1'b0;
    #12;
    vectors++; if (req_allow_o !== 1'b1) begin miscompares++; $display("FAIL rst_allow: got %0b want 1", req_allow_o); end
    vectors++; if (deq_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b want 0", deq_valid_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", count_o); end
    vectors++; if (drop_pulse_o !== 1'b0) begin miscompares++; $display("FAIL rst_drop: got %0b want 0", drop_pulse_o); end
    vectors++; if ({deq_pc_o, deq_instr_o, deq_pf_o} !== 73'd0) begin miscompares++; $display("FAIL rst_deq: got pc %0h instr %0h pf %0b want 0", deq_pc_o, deq_instr_o, deq_pf_o); end
    rstn_i = 1'b1;
  endtask

  task automatic test_basic();
    tick(); idle(); req_fire_i = 1'b1; req_pc_i = 40'h1000; #1;
    vectors++; if (req_allow_o !== 1'b1) begin miscompares++; $display("FAIL t1_allow0: got %0b want 1", req_allow_o); end
    tick(); req_pc_i = 40'h1004; #1;
    vectors++; if (req_allow_o !== 1'b1) begin miscompares++; $display("FAIL t1_allow1: got %0b want 1", req_allow_o); end
    tick(); idle(); resp_valid_i = 1'b1; resp_data_i = 32'h00000013; deq_ready_i = 1'b1; #1;
    vectors++; if (req_allow_o !== 1'b0) begin miscompares++; $display("FAIL t1_allow_max_inflight: got %0b want 0", req_allow_o); end
    vectors++; if (deq_valid_o !== 1'b0) begin miscompares++; $display("FAIL t1_latency: got %0b want 0", deq_valid_o); end
    tick(); resp_data_i = 32'h00100093; #1;
    vectors++; if (deq_valid_o !== 1'b1 || deq_pc_o !== 40'h1000 || deq_instr_o !== 32'h13) begin miscompares++; $display("FAIL t1_first: got v%0b pc %0h instr %0h want v1 pc 1000 instr 13", deq_valid_o, deq_pc_o, deq_instr_o); end
    vectors++; if (count_o !== 3'd1) begin miscompares++; $display("FAIL t1_count1: got %0d want 1", count_o); end
    tick(); resp_valid_i = 1'b0; #1;
    vectors++; if (deq_valid_o !== 1'b1 || deq_pc_o !== 40'h1004 || deq_instr_o !== 32'h00100093) begin miscompares++; $display("FAIL t1_second: got v%0b pc %0h instr %0h want v1 pc 1004 instr 100093", deq_valid_o, deq_pc_o, deq_instr_o); end
    vectors++; if (count_o !== 3'd1) begin miscompares++; $display("FAIL t1_count_enq_deq: got %0d want 1", count_o); end
    tick(); idle(); #1;
    vectors++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || req_allow_o !== 1'b1) begin miscompares++; $display("FAIL t1_empty: got count %0d v%0b allow %0b want 0 0 1", count_o, deq_valid_o, req_allow_o); end
  endtask

  task automatic test_credit();
    logic [6:0] fire_v  = 7'b0011011;
    logic [6:0] resp_v  = 7'b0111100;
    logic [6:0] allow_v = 7'b0011011;
    int k = 0;
    int r = 0;
    for (int c = 0; c < 7; c++) begin
      tick(); idle();
      req_fire_i   = fire_v[c];
      req_pc_i     = 40'h3000 + 40'(4 * k);
      resp_valid_i = resp_v[c];
      resp_data_i  = 32'h100 + 32'(r);
      if (fire_v[c]) k++;
      if (resp_v[c]) r++;
      #1;
      vectors++; if (req_allow_o !== allow_v[c]) begin miscompares++; $display("FAIL t2_allow_c%0d: got %0b want %0b", c, req_allow_o, allow_v[c]); end
    end
    tick(); idle(); #1;
    vectors++; if (count_o !== 3'd4 || req_allow_o !== 1'b0) begin miscompares++; $display("FAIL t2_full: got count %0d allow %0b want 4 0", count_o, req_allow_o); end
    vectors++; if (deq_pc_o !== 40'h3000 || deq_instr_o !== 32'h100) begin miscompares++; $display("FAIL t2_head: got pc %0h instr %0h want 3000 100", deq_pc_o, deq_instr_o); end
    deq_ready_i = 1'b1; #1;
    vectors++; if (req_allow_o !== 1'b0) begin miscompares++; $display("FAIL t2_allow_deq_cycle: got %0b want 0", req_allow_o); end
    tick(); deq_ready_i = 1'b0; #1;
    vectors++; if (count_o !== 3'd3 || req_allow_o !== 1'b1) begin miscompares++; $display("FAIL t2_after_deq: got count %0d allow %0b want 3 1", count_o, req_allow_o); end
    for (int i = 1; i < 4; i++) begin
      deq_ready_i = 1'b1; #1;
      vectors++; if (deq_pc_o !== 40'h3000 + 40'(4 * i) || deq_instr_o !== 32'h100 + 32'(i)) begin miscompares++; $display("FAIL t2_order_%0d: got pc %0h instr %0h", i, deq_pc_o, deq_instr_o); end
      tick();
    end
    deq_ready_i = 1'b0; #1;
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL t2_drained: got %0d want 0", count_o); end
  endtask

  task automatic test_flush_drain();
    tick(); idle(); req_fire_i = 1'b1; req_pc_i = 40'h4000;
    tick(); req_pc_i = 40'h4004;
    tick(); idle(); flush_i = 1'b1; #1;
    vectors++; if (req_allow_o !== 1'b0) begin miscompares++; $display("FAIL t3_allow_flush: got %0b want 0", req_allow_o); end
    tick(); flush_i = 1'b0; #1;
    vectors++; if (req_allow_o !== 1'b0 || count_o !== 3'd0 || deq_valid_o !== 1'b0 || drop_pulse_o !== 1'b0) begin miscompares++; $display("FAIL t3_drain_entry: got allow %0b count %0d v%0b drop %0b want 0 0 0 0", req_allow_o, count_o, deq_valid_o, drop_pulse_o); end
    resp_valid_i = 1'b1; resp_data_i = 32'h11; #1;
    vectors++; if (drop_pulse_o !== 1'b1) begin miscompares++; $display("FAIL t3_drop1: got %0b want 1", drop_pulse_o); end
    tick(); resp_data_i = 32'h22; #1;
    vectors++; if (drop_pulse_o !== 1'b1 || req_allow_o !== 1'b0 || count_o !== 3'd0) begin miscompares++; $display("FAIL t3_drop2: got drop %0b allow %0b count %0d want 1 0 0", drop_pulse_o, req_allow_o, count_o); end
    tick(); idle(); #1;
    vectors++; if (req_allow_o !== 1'b1 || count_o !== 3'd0 || deq_valid_o !== 1'b0 || drop_pulse_o !== 1'b0) begin miscompares++; $display("FAIL t3_resume: got allow %0b count %0d v%0b drop %0b want 1 0 0 0", req_allow_o, count_o, deq_valid_o, drop_pulse_o); end
  endtask

  task automatic test_flush_collision();
    tick(); idle(); req_fire_i = 1'b1; req_pc_i = 40'h5000;
    tick(); req_pc_i = 40'h5004; flush_i = 1'b1; resp_valid_i = 1'b1; resp_data_i = 32'h55;
    tick(); idle(); #1;
    vectors++; if (req_allow_o !== 1'b0 || count_o !== 3'd0 || deq_valid_o !== 1'b0) begin miscompares++; $display("FAIL t4_drain: got allow %0b count %0d v%0b want 0 0 0", req_allow_o, count_o, deq_valid_o); end
    resp_valid_i = 1'b1; resp_data_i = 32'h66; #1;
    vectors++; if (drop_pulse_o !== 1'b1) begin miscompares++; $display("FAIL t4_drop: got %0b want 1", drop_pulse_o); end
    tick(); idle(); #1;
    vectors++; if (req_allow_o !== 1'b1 || count_o !== 3'd0 || drop_pulse_o !== 1'b0) begin miscompares++; $display("FAIL t4_resume: got allow %0b count %0d drop %0b want 1 0 0", req_allow_o, count_o, drop_pulse_o); end
  endtask

  task automatic test_page_fault();
    tick(); idle(); req_fire_i = 1'b1; req_pc_i = 40'h2000;
    tick(); idle(); resp_valid_i = 1'b1; resp_pf_i = 1'b1; resp_data_i = 32'hDEADBEEF;
    tick(); idle(); #1;
    vectors++; if (deq_valid_o !== 1'b1 || deq_pf_o !== 1'b1 || deq_instr_o !== 32'h0 || deq_pc_o !== 40'h2000) begin miscompares++; $display("FAIL t5_pf: got v%0b pf %0b instr %0h pc %0h want v1 pf1 instr 0 pc 2000", deq_valid_o, deq_pf_o, deq_instr_o, deq_pc_o); end
    deq_ready_i = 1'b1;
    tick(); idle(); #1;
    vectors++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0) begin miscompares++; $display("FAIL t5_drained: got count %0d v%0b want 0 0", count_o, deq_valid_o); end
  endtask

  task automatic test_reset_mid_drain();
    tick(); idle(); req_fire_i = 1'b1; req_pc_i = 40'h7000;
    tick(); req_pc_i = 40'h7004;
    tick(); idle(); resp_valid_i = 1'b1; resp_data_i = 32'h70;
    tick(); req_fire_i = 1'b1; req_pc_i = 40'h7008; resp_data_i = 32'h71;
    tick(); req_pc_i = 40'h700C; resp_data_i = 32'h72;
    tick(); idle(); #1;
    vectors++; if (count_o !== 3'd3 || req_allow_o !== 1'b0) begin miscompares++; $display("FAIL t6_prefill: got count %0d allow %0b want 3 0", count_o, req_allow_o); end
    flush_i = 1'b1;
    tick(); idle(); #1;
    vectors++; if (req_allow_o !== 1'b0) begin miscompares++; $display("FAIL t6_in_drain: got allow %0b want 0", req_allow_o); end
    #2; rstn_i = 1'b0; resp_valid_i = 1'b1; #1;
    vectors++; if (req_allow_o !== 1'b1 || deq_valid_o !== 1'b0 || count_o !== 3'd0 || drop_pulse_o !== 1'b0) begin miscompares++; $display("FAIL t6_rst_ctrl: got allow %0b v%0b count %0d drop %0b want 1 0 0 0", req_allow_o, deq_valid_o, count_o, drop_pulse_o); end
    vectors++; if ({deq_pc_o, deq_instr_o, deq_pf_o} !== 73'd0) begin miscompares++; $display("FAIL t6_rst_deq: got pc %0h instr %0h pf %0b want 0", deq_pc_o, deq_instr_o, deq_pf_o); end
    idle();
    tick(); rstn_i = 1'b1;
    tick(); #1;
    vectors++; if (deq_valid_o !== 1'b0 || count_o !== 3'd0 || req_allow_o !== 1'b1) begin miscompares++; $display("FAIL t6_post_release: got v%0b count %0d allow %0b want 0 0 1", deq_valid_o, count_o, req_allow_o); end
    req_fire_i = 1'b1; req_pc_i = 40'h6000;
    tick(); idle(); resp_valid_i = 1'b1; resp_data_i = 32'h77;
    tick(); idle(); #1;
    vectors++; if (count_o !== 3'd1 || deq_pc_o !== 40'h6000 || deq_instr_o !== 32'h77) begin miscompares++; $display("FAIL t6_fresh: got count %0d pc %0h instr %0h want 1 6000 77", count_o, deq_pc_o, deq_instr_o); end
    deq_ready_i = 1'b1;
    tick(); idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_flush_drain();
    test_flush_collision();
    test_page_fault();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
